// File: rtl/gray_pkg.sv
// Shared types, default sizes and the Gray-to-binary decode helper for
// the Gray decoder monitor.
package gray_pkg;

    localparam int N_DEF      = 4;
    localparam int ERR_W_DEF  = 8;
    localparam int GRAY_MAX_W = 32;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width-generic decode: callers zero-extend a narrower Gray word to
    // GRAY_MAX_W, which leaves the low result bits exact for any width.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = {GRAY_MAX_W{1'b0}};
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// N-bit two-flop synchronizer for Gray-coded buses crossing into clk.
module gray_sync #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta_r;
    logic [N-1:0] sync_r;

    // Two-stage resynchronisation chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= {N{1'b0}};
            sync_r <= {N{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/gray_decoder_monitor.sv
// Gray count decoder with step/wrap/illegal-jump checking and a saturating
// error counter. Define GRAY_DECODER_SYNC_EN to insert a two-flop input synchronizer.
module gray_decoder_monitor
    import gray_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     gray_in,
    output logic [N-1:0]     bin_out,
    output logic             bin_valid,
    output logic             step,
    output logic             wrap,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [N-1:0]     ONE_N   = N'(1'b1);
    localparam logic [N-1:0]     ZERO_N  = {N{1'b0}};
    localparam logic [N-1:0]     ALL_N   = {N{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1'b1);

    logic [N-1:0] g_q_s;
    logic         cap_vld_s;

`ifdef GRAY_DECODER_SYNC_EN
    logic [1:0] vld_pipe_r;

    gray_sync #(.N(N)) u_gray_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gray_in),
        .q     (g_q_s)
    );

    // Marks when the synchronizer holds a real post-reset sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_r <= 2'b00;
        end else begin
            vld_pipe_r <= {vld_pipe_r[0], 1'b1};
        end
    end

    assign cap_vld_s = vld_pipe_r[1];
`else
    logic [N-1:0] g_q_r;
    logic         cap_vld_r;

    // Single capture register plus its sample-present flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_q_r     <= {N{1'b0}};
            cap_vld_r <= 1'b0;
        end else begin
            g_q_r     <= gray_in;
            cap_vld_r <= 1'b1;
        end
    end

    assign g_q_s     = g_q_r;
    assign cap_vld_s = cap_vld_r;
`endif

    state_t           state_r;
    state_t           state_nxt_s;
    logic [N-1:0]     bin_next_s;
    logic [N-1:0]     delta_s;
    logic [N-1:0]     bin_out_r;
    logic             bin_valid_r;
    logic             step_r;
    logic             wrap_r;
    logic             err_r;
    logic [ERR_W-1:0] err_cnt_r;
    logic             valid_nxt_s;
    logic             step_nxt_s;
    logic             wrap_nxt_s;
    logic             err_nxt_s;
    logic [ERR_W-1:0] cnt_nxt_s;

    assign bin_next_s = N'(gray2bin(GRAY_MAX_W'(g_q_s)));
    assign delta_s    = bin_next_s - bin_out_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and next flag values; the first sample only arms checking.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = bin_valid_r;
        step_nxt_s  = 1'b0;
        wrap_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        cnt_nxt_s   = err_cnt_r;
        case (state_r)
            INIT: begin
                if (cap_vld_s) begin
                    state_nxt_s = RUN;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN: begin
                valid_nxt_s = 1'b1;
                if (delta_s == ZERO_N) begin
                    step_nxt_s = 1'b0;
                end else if (delta_s == ONE_N) begin
                    step_nxt_s = 1'b1;
                    wrap_nxt_s = (bin_out_r == ALL_N);
                end else begin
                    err_nxt_s = 1'b1;
                    if (err_cnt_r != ERR_MAX) begin
                        cnt_nxt_s = err_cnt_r + ERR_ONE;
                    end else begin
                        cnt_nxt_s = err_cnt_r;
                    end
                end
            end
            default: begin
                state_nxt_s = INIT;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; bin_out always follows the decode so checking resyncs after an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_out_r   <= {N{1'b0}};
            bin_valid_r <= 1'b0;
            step_r      <= 1'b0;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= {ERR_W{1'b0}};
        end else begin
            bin_out_r   <= bin_next_s;
            bin_valid_r <= valid_nxt_s;
            step_r      <= step_nxt_s;
            wrap_r      <= wrap_nxt_s;
            err_r       <= err_nxt_s;
            err_cnt_r   <= cnt_nxt_s;
        end
    end

    assign bin_out   = bin_out_r;
    assign bin_valid = bin_valid_r;
    assign step      = step_r;
    assign wrap      = wrap_r;
    assign err       = err_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: doc/gray_decoder_monitor.md
# gray_decoder_monitor

Receive-side companion to the Gray counter. Samples an N-bit Gray count, decodes it to binary through a registered pipeline, and checks every new value against the previous one. Flags a legal single-step advance, a wrap-around, or an illegal jump, and keeps a saturating error count. Sits at the consumer end of any Gray-coded pointer or counter bus, such as FIFO pointers or position counters.

## Interface
- N, default 4: width of the Gray input and of the binary output.
- ERR_W, default 8: width of the saturating error counter.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- gray_in  in  N  Gray-coded count from an up-counting Gray counter.
- bin_out  out  N  registered binary decode of the sampled Gray value.
- bin_valid  out  1  high from the first decoded sample after reset onward.
- step  out  1  one-cycle pulse when the new value equals the previous value +1 mod 2^N.
- wrap  out  1  one-cycle pulse when the value advances from 2^N-1 to 0; always coincides with step.
- err  out  1  one-cycle pulse when the new value differs from the previous value by anything other than 0 or +1.
- err_cnt  out  ERR_W  count of err pulses since reset; saturates at 2^ERR_W-1.

## Operation
- Capture stage: gray_in is registered into g_q every cycle. With the sync option, a two-flop synchronizer replaces this stage.
- Decode stage: bin_next = gray2bin(g_q), where b[N-1]=g[N-1] and b[i]=b[i+1]^g[i]. bin_next is registered into bin_out every cycle.
- State machine, two states:
  - INIT (reset state): on the first decode-stage update, load bin_out, set bin_valid=1 and go to RUN. No step, wrap or err pulse is issued for this sample.
  - RUN: each cycle, compute delta = (bin_next - bin_out) mod 2^N in N-bit arithmetic.
    - delta=0: no pulse.
    - delta=1: step=1. Also wrap=1 if bin_out=2^N-1.
    - Any other delta, including -1: err=1, and err_cnt increments unless it is already saturated.
- bin_out always takes the new value, errors included, so checking resynchronises to the new position.
- The machine only leaves RUN through reset.
- reset low at any time: the capture/sync registers, bin_out, bin_valid, step, wrap, err and err_cnt all go to 0 and the state goes to INIT, asynchronously. Release is synchronous to clk.

## Timing
- Every output is registered. Reset value of every output is 0.
- Latency without the sync option: gray_in sampled at edge k appears on bin_out after edge k+1, with its flags.
- Latency with the sync option: gray_in sampled at edge k appears on bin_out after edge k+2.
- step, wrap and err assert in the same cycle that bin_out changes to the value that caused them. Each is high for exactly one cycle per event.
- bin_valid rises in the cycle the first decoded value is presented.
- gray_in may change every cycle. Each sampled value is checked against the immediately preceding one; there is no back-pressure.
- err_cnt at 2^ERR_W-1: err still pulses, but the count holds.

## Configuration
- GRAY_DECODER_SYNC_EN defined: gray_in passes through a two-flop synchronizer (gray_sync). Use this when gray_in comes from another clock domain. Adds one cycle of latency.
- GRAY_DECODER_SYNC_EN undefined: gray_in is captured by a single register. The source must be in the clk domain.
- All flag semantics are identical in both builds; only latency differs.

## Structure
- Package gray_pkg holds:
  - the gray2bin function, parameterised by width;
  - the state enum {INIT, RUN};
  - the default constants N=4 and ERR_W=8.
- Sub-module gray_sync: an N-bit, two-flop synchronizer with asynchronous active-low reset. It is instantiated only under GRAY_DECODER_SYNC_EN.
- Decode, compare and counter logic live in the top module.

## Test plan
- Counting, N=4: drive gray_in with 0000, 0001, 0011, 0010, 0110 on consecutive cycles. Expect bin_out = 0, 1, 2, 3, 4, with bin_valid rising on the 0 and step pulsing on 1, 2, 3 and 4. err stays 0.
- Wrap: drive 1001 (14), then 1000 (15), then 0000 (0). Expect step on 15 and on 0, with wrap=1 only on the 15→0 transition.
- Illegal jump: drive 0010 (3), then 0111 (5). Expect err=1 for one cycle, err_cnt=1 and bin_out=5. Follow with 0101 (6); expect step=1 and no err.
- Hold and reverse: hold gray_in at 0110 (4) for 10 cycles; expect no pulses. Then drive 0010 (3); expect err=1, because a -1 step is illegal.
- Saturation: drive 300 alternating values, 0000 and 1100 (0 and 8). Expect err_cnt to stop at 255 while err keeps pulsing.
- Reset mid-run: pull reset low while bin_out=7 and err_cnt=2. Expect all outputs 0 immediately. After release, the first sample only sets bin_valid, with no step or err.
- Repeat all scenarios with GRAY_DECODER_SYNC_EN defined and check that every response shifts by exactly one cycle.
